// File: rtl/stamp_inserter.sv
// Receive-path stamp inserter: writes the free-running stamp into tuser of each packet's first beat,
// then forwards the stream through a 2-entry skid FIFO and counts forwarded packets.
module stamp_inserter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int TS_TUSER_POS         = 32
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_reset,
  input  logic [TIMESTAMP_WIDTH-1:0]           stamp_counter,
  input  logic                                 stamp_enable,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_count
);

  localparam int STRB_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = C_S_AXIS_DATA_WIDTH + STRB_WIDTH + C_S_AXIS_TUSER_WIDTH + 1;

  generate
    if (TS_TUSER_POS + TIMESTAMP_WIDTH > C_S_AXIS_TUSER_WIDTH) begin : g_bad_stamp_pos
      $error("stamp_inserter: stamp field does not fit inside tuser");
    end
  endgenerate

  typedef enum logic {SOF, IN_PKT} state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [ENTRY_WIDTH-1:0]         mem [2];
  logic                           wr_ptr;
  logic                           rd_ptr;
  logic [1:0]                     count;
  logic [1:0]                     count_d;
  logic                           wr_en;
  logic                           rd_en;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_stamped;
  logic [ENTRY_WIDTH-1:0]         wr_entry;
  logic [ENTRY_WIDTH-1:0]         head;

  // Handshakes: a beat moves on a cycle where valid and ready are both 1; valid never waits on ready,
  // and s_axis_tready is a register holding "FIFO not full" for the current cycle.
  assign wr_en = s_axis_tvalid & s_axis_tready;
  assign rd_en = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state_q <= SOF;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wr_en) begin
      case (state_q)
        SOF:     state_d = s_axis_tlast ? SOF : IN_PKT;
        IN_PKT:  state_d = s_axis_tlast ? SOF : IN_PKT;
        default: state_d = SOF;
      endcase
    end
  end

  always_comb begin
    user_stamped = s_axis_tuser;
    if (state_q == SOF && stamp_enable)
      user_stamped[TS_TUSER_POS +: TIMESTAMP_WIDTH] = stamp_counter;
  end

  assign wr_entry = {s_axis_tdata, s_axis_tstrb, user_stamped, s_axis_tlast};

  always_comb begin
    case ({wr_en, rd_en})
      2'b10:   count_d = count + 2'd1;
      2'b01:   count_d = count - 2'd1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      mem[0]        <= '0;
      mem[1]        <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      s_axis_tready <= 1'b0;
      pkt_count     <= 32'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      count         <= count_d;
      s_axis_tready <= (count_d != 2'd2);
      if (rd_en && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end

  // The head entry is only overwritten after it has been read, so it stays stable under backpressure.
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != 2'd0);
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = head;

endmodule

// File: tb/tb_stamp_inserter.sv
// Self-checking bench for stamp_inserter: directed scenarios plus random traffic, all checked
// against a queue-based packet model that stamps the first beat of every accepted packet.
module tb_stamp_inserter;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int TW = 64;
  localparam int TP = 32;
  localparam int BW = DW + SW + UW + 1;

  logic           clk;
  logic           axi_reset;
  logic [TW-1:0]  stamp_counter;
  logic           stamp_enable;
  logic [DW-1:0]  s_axis_tdata;
  logic [SW-1:0]  s_axis_tstrb;
  logic [UW-1:0]  s_axis_tuser;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [DW-1:0]  m_axis_tdata;
  logic [SW-1:0]  m_axis_tstrb;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [31:0]    pkt_count;

  stamp_inserter #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .TIMESTAMP_WIDTH(TW), .TS_TUSER_POS(TP)
  ) dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .stamp_counter(stamp_counter), .stamp_enable(stamp_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stamp source: free-running counter, optionally reloaded by a test.
  logic          stamp_load;
  logic [TW-1:0] stamp_val;
  initial begin
    stamp_counter = 64'h1234_0000_0000_0000;
    stamp_load    = 1'b0;
    stamp_val     = '0;
    forever begin
      @(posedge clk);
      #3;
      if (stamp_load) begin
        stamp_counter = stamp_val;
        stamp_load    = 1'b0;
      end else begin
        stamp_counter = stamp_counter + 64'd1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [UW-1:0] obs_user_q[$];
  int            obs_cyc_q[$];
  logic [TW-1:0] acc_stamp_q[$];
  logic [31:0]   exp_cnt = 32'd0;
  bit            in_pkt = 1'b0;
  bit            after_rst = 1'b0;
  int            acc_cnt = 0;
  int            cyc = 0;

  always @(negedge clk) begin
    logic [BW-1:0] e;
    logic [UW-1:0] u;
    cyc++;
    if (axi_reset) begin
      exp_q.delete();
      in_pkt    = 1'b0;
      exp_cnt   = 32'd0;
      after_rst = 1'b1;
    end else begin
      check("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
      check("s_tready", s_axis_tready, !after_rst && exp_q.size() < 2);
      check("pkt_count", pkt_count, exp_cnt);
      after_rst = 1'b0;
      if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_tdata", m_axis_tdata, e[BW-1 -: DW]);
        check("out_tstrb", m_axis_tstrb, e[UW+SW : UW+1]);
        check("out_tuser", m_axis_tuser, e[UW:1]);
        check("out_tlast", m_axis_tlast, e[0]);
        if (e[0]) exp_cnt = exp_cnt + 32'd1;
        obs_user_q.push_back(m_axis_tuser);
        obs_cyc_q.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) begin
        u = s_axis_tuser;
        if (!in_pkt && stamp_enable) u[TP +: TW] = stamp_counter;
        exp_q.push_back({s_axis_tdata, s_axis_tstrb, u, s_axis_tlast});
        in_pkt = !s_axis_tlast;
        acc_cnt++;
        acc_stamp_q.push_back(stamp_counter);
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] data, input logic [UW-1:0] user,
                           input logic last, input logic en);
    int n;
    s_axis_tdata  = data;
    s_axis_tstrb  = data[SW-1:0] ^ SW'($urandom());
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    stamp_enable  = en;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      if (exp_q.size() == 0 && !m_axis_tvalid) return;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic clear_logs();
    obs_user_q.delete();
    obs_cyc_q.delete();
    acc_stamp_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [UW-1:0] pat5a;
    int acc0;
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    stamp_enable  = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tuser", m_axis_tuser, '0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_pkt_count", pkt_count, 32'd0);
    axi_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: three single-beat packets on consecutive cycles, stamps from 0x100
    clear_logs();
    stamp_val  = 64'h100;
    stamp_load = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(rand_data(), '0, 1'b1, 1'b1);
    drain();
    check("t1_beats", obs_user_q.size(), 3);
    if (obs_user_q.size() == 3) begin
      for (int i = 0; i < 3; i++) check("t1_stamp", obs_user_q[i][95:32], 64'h100 + 64'(i));
      check("t1_consecutive", obs_cyc_q[2] - obs_cyc_q[0], 2);
    end
    check("t1_pkt_count", pkt_count, 32'd3);

    // 2: 4-beat packet with all-ones tuser
    clear_logs();
    for (int i = 0; i < 4; i++) send_beat(rand_data(), '1, i == 3, 1'b1);
    drain();
    check("t2_beats", obs_user_q.size(), 4);
    if (obs_user_q.size() == 4) begin
      check("t2_beat0", obs_user_q[0], {32'hFFFF_FFFF, acc_stamp_q[0], 32'hFFFF_FFFF});
      for (int i = 1; i < 4; i++) check("t2_tail", obs_user_q[i], {UW{1'b1}});
    end

    // 3: backpressure with a continuous input stream
    m_axis_tready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(rand_data(), rand_data()[UW-1:0], i == 5, 1'b1);
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("t3_accepted", acc_cnt - acc0, 2);
    check("t3_tready_low", s_axis_tready, 1'b0);
    m_axis_tready = 1'b1;
    wait fork;
    drain();
    check("t3_all_accepted", acc_cnt - acc0, 6);

    // 4: stamp_enable=0 leaves tuser untouched
    clear_logs();
    pat5a = {16{8'h5A}};
    for (int i = 0; i < 2; i++) send_beat(rand_data(), pat5a, i == 1, 1'b0);
    drain();
    check("t4_beats", obs_user_q.size(), 2);
    if (obs_user_q.size() == 2) begin
      check("t4_beat0", obs_user_q[0], pat5a);
      check("t4_beat1", obs_user_q[1], pat5a);
    end

    // 5: reset after beat 2 of a 5-beat packet; the tail restarts as a stamped packet
    for (int i = 0; i < 3; i++) send_beat(rand_data(), '0, 1'b0, 1'b1);
    axi_reset = 1'b1;
    @(posedge clk);
    #1;
    axi_reset = 1'b0;
    check("t5_tvalid", m_axis_tvalid, 1'b0);
    check("t5_pkt_count", pkt_count, 32'd0);
    clear_logs();
    for (int i = 3; i < 5; i++) send_beat(rand_data(), '0, i == 4, 1'b1);
    drain();
    check("t5_beats", obs_user_q.size(), 2);
    if (obs_user_q.size() == 2) begin
      check("t5_restamp", obs_user_q[0][95:32], acc_stamp_q[0]);
      check("t5_tail", obs_user_q[1], '0);
    end
    check("t5_pkt_after", pkt_count, 32'd1);

    // 6: pkt_count wrap
    force dut.pkt_count = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.pkt_count;
    send_beat(rand_data(), rand_data()[UW-1:0], 1'b1, 1'b1);
    drain();
    check("t6_ffffffff", pkt_count, 32'hFFFF_FFFF);
    send_beat(rand_data(), rand_data()[UW-1:0], 1'b1, 1'b1);
    drain();
    check("t6_zero", pkt_count, 32'd0);
    send_beat(rand_data(), rand_data()[UW-1:0], 1'b1, 1'b1);
    drain();
    check("t6_one", pkt_count, 32'd1);

    // 7: random traffic with random output backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        send_beat(rand_data(), rand_data()[UW-1:0], b == len - 1, $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    m_axis_tready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
